pulse_cdc_sched: RTL and testbench

Transmit-side scheduler that shares one toggle-based pulse synchronizer between several requesters. Round-robin arbitration picks one pending event, fires one single-cycle pulse into the synchronizer, and waits for the return acknowledge pulse. It then enforces a guard gap so consecutive toggles are never closer than the synchronizer can resolve. It sits entirely in the source clock domain; `ack_i` arrives already synchronized by a return-path synchronizer.

---
 rtl/pulse_cdc_pkg.sv | 15 +
 rtl/pulse_cdc_sched_rr_arbiter.sv | 34 +++
 rtl/pulse_cdc_sched.sv | 136 +++++++++++++
 tb/tb_pulse_cdc_sched.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_cdc_pkg.sv
// Shared types and constants for the pulse CDC scheduler.
package pulse_cdc_pkg;

  // Transaction life cycle of the shared synchronizer
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } state_t;

  // Idle cycles forced after each transaction unless overridden
  localparam int DEFAULT_MIN_GAP = 4;

endpackage

// File: rtl/pulse_cdc_sched_rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after the
// pointer (wrapping at N_REQ-1 back to 0) wins.
module rr_arbiter
  import pulse_cdc_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   idx,
  output logic             valid
);

  logic [IDW-1:0] cand;

  // Scan from the farthest offset down so the nearest set bit is kept last
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = IDW'((int'(ptr) + i) % N_REQ);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/pulse_cdc_sched.sv
// Round-robin scheduler sharing one toggle pulse synchronizer among
// N_REQ requesters: grant, fire one pulse, wait for the returned ack,
// then hold a guard gap before the next launch.
// Optional: define CDC_TIMEOUT_EN to abandon transactions whose ack never
// returns within TIMEOUT WAIT cycles.
module pulse_cdc_sched
  import pulse_cdc_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MIN_GAP = DEFAULT_MIN_GAP,
  parameter int TIMEOUT = 64,
  parameter int IDW     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             pulse_o,
  output logic [IDW-1:0]   pulse_id_o,
  input  logic             ack_i,
  output logic             done_o,
  output logic             timeout_o,
  output logic             busy_o
);

  localparam int GW = $clog2(MIN_GAP + 1);

  state_t           state;
  state_t           state_nx;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   win_idx;
  logic [N_REQ-1:0] win_gnt;
  logic             win_valid;
  logic [N_REQ-1:0] gnt_q;
  logic [GW-1:0]    gap_cnt;
  logic             ack_hit;
  logic             to_hit;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .req   (req_i),
    .ptr   (rr_ptr),
    .gnt   (win_gnt),
    .idx   (win_idx),
    .valid (win_valid)
  );

  // An ack only counts while a transaction is outstanding
  assign ack_hit = (state == WAIT) && ack_i;

`ifdef CDC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;

  // Counts WAIT cycles; held at zero elsewhere so every WAIT starts fresh
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  end

  // Terminal count on the last allowed WAIT cycle; a coincident ack wins
  assign to_hit = (state == WAIT) && !ack_i && (wait_cnt == TW'(TIMEOUT - 1));

  // Registered abandon strobe, one cycle after the terminal count
  always_ff @(posedge clk) begin
    if (rst) timeout_o <= 1'b0;
    else     timeout_o <= to_hit;
  end
`else
  assign to_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (win_valid) state_nx = LAUNCH;
      LAUNCH:  state_nx = WAIT;
      WAIT:    if (ack_hit || to_hit) state_nx = GAP;
      GAP:     if (gap_cnt <= GW'(1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Transaction bookkeeping: winner latch, RR pointer, gap timer, done strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      pulse_id_o <= '0;
      gnt_q      <= '0;
      gap_cnt    <= '0;
      done_o     <= 1'b0;
    end else begin
      done_o <= ack_hit;
      if (state == IDLE && win_valid) begin
        pulse_id_o <= win_idx;
        gnt_q      <= win_gnt;
      end
      if (state == LAUNCH) begin
        rr_ptr <= (pulse_id_o == IDW'(N_REQ - 1)) ? '0 : pulse_id_o + IDW'(1);
      end
      if (state == WAIT && (ack_hit || to_hit)) begin
        gap_cnt <= GW'(MIN_GAP);
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
    end
  end

  // Pulse, grant and busy are decoded purely from registered state
  always_comb begin
    pulse_o = 1'b0;
    gnt_o   = '0;
    busy_o  = (state != IDLE);
    if (state == LAUNCH) begin
      pulse_o = 1'b1;
      gnt_o   = gnt_q;
    end
  end

endmodule

// File: tb/tb_pulse_cdc_sched.sv
// Self-checking bench for pulse_cdc_sched: timestamp-based transaction
// model, directed scenarios with literal expectations, then random traffic.
module tb_pulse_cdc_sched;

  localparam int N_REQ   = 4;
  localparam int MIN_GAP = 4;
  localparam int TIMEOUT = 8;
  localparam int IDW     = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] gnt_o;
  logic             pulse_o;
  logic [IDW-1:0]   pulse_id_o;
  logic             ack_i;
  logic             done_o;
  logic             timeout_o;
  logic             busy_o;

  int vectors     = 0;
  int miscompares = 0;

  // Model: cycle counter plus timestamps of the current transaction
  int             cyc    = 0;
  bit             m_txn  = 1'b0;
  int             m_l    = 0;
  int             m_r    = 0;
  bit             m_res  = 1'b0;
  bit             m_to   = 1'b0;
  int             m_id   = 0;
  int             m_ptr  = 0;
  logic [IDW-1:0] m_last_id = '0;

  pulse_cdc_sched #(
    .N_REQ   (N_REQ),
    .MIN_GAP (MIN_GAP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .pulse_o    (pulse_o),
    .pulse_id_o (pulse_id_o),
    .ack_i      (ack_i),
    .done_o     (done_o),
    .timeout_o  (timeout_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  // Free to accept a request: no transaction, or its gap has fully elapsed
  function automatic bit modelIdle(input int c);
    return !m_txn || (m_res && c >= m_r + 1 + MIN_GAP);
  endfunction

  // Advance the model by one cycle given that cycle's inputs
  task automatic modelStep(input bit r, input logic [N_REQ-1:0] q, input bit a);
    int c;
    int j;
    c = cyc;
    if (r) begin
      m_txn     = 1'b0;
      m_ptr     = 0;
      m_last_id = '0;
    end else if (modelIdle(c)) begin
      if (q != '0) begin
        j = -1;
        for (int k = 0; k < N_REQ; k++) begin
          if (j < 0 && q[(m_ptr + k) % N_REQ]) j = (m_ptr + k) % N_REQ;
        end
        m_txn     = 1'b1;
        m_l       = c + 1;
        m_id      = j;
        m_res     = 1'b0;
        m_last_id = IDW'(j);
        m_ptr     = (j + 1) % N_REQ;
      end
    end else if (!m_res && c > m_l) begin
      if (a) begin
        m_res = 1'b1;
        m_r   = c;
        m_to  = 1'b0;
      end
`ifdef CDC_TIMEOUT_EN
      else if (c == m_l + TIMEOUT) begin
        m_res = 1'b1;
        m_r   = c;
        m_to  = 1'b1;
      end
`endif
    end
    cyc++;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Compare every output against the model for the current cycle
  task automatic checkOutput();
    bit             pulse_e;
    logic [N_REQ-1:0] gnt_e;
    pulse_e = m_txn && (cyc == m_l);
    gnt_e   = pulse_e ? N_REQ'(1 << m_id) : '0;
    cmp("pulse_o",    32'(pulse_o),    32'(pulse_e));
    cmp("gnt_o",      32'(gnt_o),      32'(gnt_e));
    cmp("pulse_id_o", 32'(pulse_id_o), 32'(m_last_id));
    cmp("done_o",     32'(done_o),     32'(m_txn && m_res && !m_to && cyc == m_r + 1));
    cmp("timeout_o",  32'(timeout_o),  32'(m_txn && m_res && m_to && cyc == m_r + 1));
    cmp("busy_o",     32'(busy_o),     32'(!modelIdle(cyc)));
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge
  task automatic applyStimulus(input bit r, input logic [N_REQ-1:0] q, input bit a);
    rst   = r;
    req_i = q;
    ack_i = a;
    modelStep(r, q, a);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idleTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0);
  endtask

  logic [N_REQ-1:0] order [5];
  logic [N_REQ-1:0] req_lvl;
  int               ack_due;
  bit               r_v;
  bit               a_v;

  initial begin
    rst   = 1'b1;
    req_i = '0;
    ack_i = 1'b0;
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;

    // Reset state
    applyStimulus(1'b1, '0, 1'b0);
    applyStimulus(1'b1, '0, 1'b0);
    cmp("reset_busy", 32'(busy_o), 32'd0);
    cmp("reset_id",   32'(pulse_id_o), 32'd0);
    cmp("reset_done", 32'(done_o), 32'd0);

    // Single request on requester 2, ack four cycles after the pulse
    applyStimulus(1'b0, 4'b0100, 1'b0);
    cmp("single_pulse", 32'(pulse_o), 32'd1);
    cmp("single_gnt",   32'(gnt_o), 32'h4);
    cmp("single_id",    32'(pulse_id_o), 32'd2);
    idleTicks(4);
    applyStimulus(1'b0, '0, 1'b1);
    cmp("single_done", 32'(done_o), 32'd1);
    idleTicks(MIN_GAP - 1);
    cmp("single_gap_busy", 32'(busy_o), 32'd1);
    idleTicks(2);
    cmp("single_idle", 32'(busy_o), 32'd0);

    // Fairness: all requesters held, ack three cycles after each pulse
    applyStimulus(1'b1, '0, 1'b0);
    applyStimulus(1'b0, 4'hF, 1'b0);
    cmp("fair_gnt0", 32'(gnt_o), 32'(order[0]));
    for (int k = 1; k < 5; k++) begin
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'hF, 1'b0);
      applyStimulus(1'b0, 4'hF, 1'b1);
      for (int i = 0; i < MIN_GAP + 1; i++) applyStimulus(1'b0, 4'hF, 1'b0);
      cmp("fair_pulse", 32'(pulse_o), 32'd1);
      cmp("fair_gnt",   32'(gnt_o), 32'(order[k]));
    end
    idleTicks(3);
    applyStimulus(1'b0, '0, 1'b1);
    idleTicks(MIN_GAP + 1);

    // Spurious acks in IDLE, LAUNCH and GAP
    applyStimulus(1'b0, '0, 1'b1);
    cmp("spur_idle_done", 32'(done_o), 32'd0);
    cmp("spur_idle_busy", 32'(busy_o), 32'd0);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    cmp("spur_launch_done", 32'(done_o), 32'd0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    cmp("spur_real_done", 32'(done_o), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);
    cmp("spur_gap_done", 32'(done_o), 32'd0);
    idleTicks(MIN_GAP);
    cmp("spur_gap_end", 32'(busy_o), 32'd0);

`ifdef CDC_TIMEOUT_EN
    // No ack: abandon on the ninth cycle after the launch
    applyStimulus(1'b0, 4'b0010, 1'b0);
    idleTicks(TIMEOUT);
    cmp("to_before", 32'(timeout_o), 32'd0);
    idleTicks(1);
    cmp("to_fire", 32'(timeout_o), 32'd1);
    cmp("to_nodone", 32'(done_o), 32'd0);
    idleTicks(MIN_GAP + 1);
    // Ack on the terminal-count cycle wins over the timeout
    applyStimulus(1'b0, 4'b0010, 1'b0);
    idleTicks(TIMEOUT);
    applyStimulus(1'b0, '0, 1'b1);
    cmp("coll_done", 32'(done_o), 32'd1);
    cmp("coll_to",   32'(timeout_o), 32'd0);
    idleTicks(MIN_GAP + 1);
`else
    // Without the timeout option WAIT is unbounded
    applyStimulus(1'b0, 4'b0010, 1'b0);
    idleTicks(200);
    cmp("nto_busy", 32'(busy_o), 32'd1);
    cmp("nto_to",   32'(timeout_o), 32'd0);
    applyStimulus(1'b0, '0, 1'b1);
    cmp("nto_done", 32'(done_o), 32'd1);
    idleTicks(MIN_GAP + 1);
`endif

    // Reset while waiting: pointer returns to 0 and late acks are ignored
    applyStimulus(1'b0, 4'b0100, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, '0, 1'b0);
    cmp("rstw_busy",  32'(busy_o), 32'd0);
    cmp("rstw_id",    32'(pulse_id_o), 32'd0);
    cmp("rstw_pulse", 32'(pulse_o), 32'd0);
    applyStimulus(1'b0, '0, 1'b1);
    cmp("rstw_ack_ignored", 32'(done_o), 32'd0);
    applyStimulus(1'b0, 4'b1010, 1'b0);
    cmp("rstw_gnt", 32'(gnt_o), 32'h2);
    cmp("rstw_newid", 32'(pulse_id_o), 32'd1);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    idleTicks(MIN_GAP + 1);

    // Random traffic: requests rise and occasionally drop, acks arrive
    // 1..12 cycles after each pulse, with stray acks and rare resets
    req_lvl = '0;
    ack_due = -1;
    for (int n = 0; n < 3000; n++) begin
      r_v = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < N_REQ; b++) begin
        if (!req_lvl[b] && $urandom_range(0, 3) == 0) req_lvl[b] = 1'b1;
        else if (req_lvl[b] && $urandom_range(0, 63) == 0) req_lvl[b] = 1'b0;
      end
      a_v = (cyc == ack_due) || ($urandom_range(0, 19) == 0);
      applyStimulus(r_v, req_lvl, a_v);
      if (m_txn && cyc == m_l) begin
        req_lvl = req_lvl & ~N_REQ'(1 << m_id);
        ack_due = cyc + int'($urandom_range(1, 12));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
